// File: rtl/multiplier_t_c2x2_f0_16x16_simd.sv
// multiplier_t_c2x2_f0_16x16_simd: 2x2 array of 9x9 multipliers giving one 16x16 product as two partials or two SIMD sum-of-products lanes
module multiplier_t_c2x2_f0_16x16_simd (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        a_sign,
  input  logic        b_sign,
  input  logic [1:0]  mode,
  output logic [31:0] result_0,
  output logic [31:0] result_1,
  output logic [1:0]  result_SIMD_carry
);
  function automatic logic signed [8:0] ext(input logic [7:0] v, input logic s);
    return {s & v[7], v};
  endfunction
  logic simd;
  logic signed [8:0] x [4];
  logic signed [8:0] y [4];
  logic signed [17:0] m [4];
  logic signed [31:0] e [4];
  logic [16:0] s0, s1;
  logic [31:0] r0_d, r1_d;
  logic [1:0] c_d;
  logic unused;
  assign simd = mode[0];
  assign unused = mode[1];
  // the four multipliers are shared: in 16x16 mode they form ll/hh/hl/lh, in SIMD mode byte-wise pairs
  always_comb begin
    x[0] = ext(a[7:0], simd & a_sign);
    y[0] = ext(b[7:0], simd & b_sign);
    x[1] = ext(a[15:8], a_sign);
    y[1] = ext(b[15:8], b_sign);
    x[2] = simd ? ext(a[23:16], a_sign) : ext(a[15:8], a_sign);
    y[2] = simd ? ext(b[23:16], b_sign) : ext(b[7:0], 1'b0);
    x[3] = simd ? ext(a[31:24], a_sign) : ext(a[7:0], 1'b0);
    y[3] = simd ? ext(b[31:24], b_sign) : ext(b[15:8], b_sign);
  end
  for (genvar i = 0; i < 4; i++) begin : g_mul
    assign m[i] = x[i] * y[i];
    assign e[i] = {{14{m[i][17]}}, m[i]};
  end
  assign s0 = 17'(m[0]) + 17'(m[1]);
  assign s1 = 17'(m[2]) + 17'(m[3]);
  assign r0_d = simd ? {s1[15:0], s0[15:0]} : (e[1] << 16) + e[0];
  assign r1_d = simd ? 32'd0 : (e[2] + e[3]) << 8;
  assign c_d  = simd ? {s1[16], s0[16]} : 2'b00;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      result_0          <= '0;
      result_1          <= '0;
      result_SIMD_carry <= '0;
    end else begin
      result_0          <= r0_d;
      result_1          <= r1_d;
      result_SIMD_carry <= c_d;
    end
endmodule

// File: tb/tb_multiplier_t_c2x2_f0_16x16_simd.sv
// tb_multiplier_t_c2x2_f0_16x16_simd: directed and randomized checks against an arithmetic reference model
module tb_multiplier_t_c2x2_f0_16x16_simd;
  logic clk = 0, rst_n = 0;
  logic [31:0] a = 0, b = 0;
  logic a_sign = 0, b_sign = 0;
  logic [1:0] mode = 0;
  logic [31:0] result_0, result_1;
  logic [1:0] result_SIMD_carry;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  multiplier_t_c2x2_f0_16x16_simd dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .a_sign(a_sign), .b_sign(b_sign),
    .mode(mode), .result_0(result_0), .result_1(result_1), .result_SIMD_carry(result_SIMD_carry)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic longint bv(input logic [7:0] v, input logic s);
    return s ? longint'($signed(v)) : longint'(v);
  endfunction
  function automatic logic [31:0] full16(input logic [31:0] x, input logic [31:0] y, input logic xs, input logic ys);
    longint p, q;
    p = xs ? longint'($signed(x[15:0])) : longint'(x[15:0]);
    q = ys ? longint'($signed(y[15:0])) : longint'(y[15:0]);
    return 32'(p * q);
  endfunction
  task automatic model(input logic [31:0] x, input logic [31:0] y, input logic xs, input logic ys,
                       input logic [1:0] md, output logic [31:0] r0, output logic [31:0] r1, output logic [1:0] c);
    longint ah, al, bh, bl;
    logic [63:0] s0, s1;
    if (!md[0]) begin
      al = bv(x[7:0], 1'b0);
      bl = bv(y[7:0], 1'b0);
      ah = bv(x[15:8], xs);
      bh = bv(y[15:8], ys);
      r0 = 32'(ah * bh * 65536 + al * bl);
      r1 = 32'((ah * bl + al * bh) * 256);
      c  = 2'b00;
    end else begin
      s0 = 64'(bv(x[7:0], xs) * bv(y[7:0], ys) + bv(x[15:8], xs) * bv(y[15:8], ys));
      s1 = 64'(bv(x[23:16], xs) * bv(y[23:16], ys) + bv(x[31:24], xs) * bv(y[31:24], ys));
      r0 = {s1[15:0], s0[15:0]};
      r1 = 32'd0;
      c  = {s1[16], s0[16]};
    end
  endtask
  task automatic step(input logic [31:0] na, input logic [31:0] nb, input logic nas, input logic nbs, input logic [1:0] nm);
    logic [31:0] r0, r1;
    logic [1:0] c;
    a = na; b = nb; a_sign = nas; b_sign = nbs; mode = nm;
    model(na, nb, nas, nbs, nm, r0, r1, c);
    @(posedge clk);
    #1;
    chk("r0", result_0, r0);
    chk("r1", result_1, r1);
    chk("carry", {30'b0, result_SIMD_carry}, {30'b0, c});
    if (!nm[0]) chk("sum16", result_0 + result_1, full16(na, nb, nas, nbs));
  endtask
  initial begin
    logic [1:0] m;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_r0", result_0, 32'd0);
    chk("rst_r1", result_1, 32'd0);
    chk("rst_c", {30'b0, result_SIMD_carry}, 32'd0);
    rst_n = 1;
    step(32'h0000FFFF, 32'h0000FFFF, 0, 0, 2'b00);
    chk("d1_r0", result_0, 32'hFE01FE01);
    chk("d1_r1", result_1, 32'h01FC0200);
    chk("d1_sum", result_0 + result_1, 32'hFFFE0001);
    step(32'h0000FFFF, 32'h00000002, 1, 1, 2'b00);
    chk("d2_sum", result_0 + result_1, 32'hFFFFFFFE);
    step(32'h0000FFFF, 32'h00000002, 0, 1, 2'b00);
    chk("d3_sum", result_0 + result_1, 32'h0001FFFE);
    step(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 2'b01);
    chk("d4_r0", result_0, 32'hFC02FC02);
    chk("d4_r1", result_1, 32'd0);
    chk("d4_c", {30'b0, result_SIMD_carry}, 32'd3);
    step(32'h80808080, 32'h80808080, 1, 1, 2'b11);
    chk("d5_r0", result_0, 32'h80008000);
    chk("d5_c", {30'b0, result_SIMD_carry}, 32'd0);
    step(32'h80808080, 32'hFFFFFFFF, 1, 0, 2'b01);
    chk("d6_r0", result_0, 32'h01000100);
    chk("d6_c", {30'b0, result_SIMD_carry}, 32'd3);
    for (int md = 0; md < 2; md++)
      for (int sc = 0; sc < 4; sc++)
        for (int n = 0; n < 2000; n++) begin
          m = {1'($urandom_range(0, 1)), 1'(md)};
          step($urandom, $urandom, 1'(sc >> 1), 1'(sc), m);
        end
    step(32'h1234FFFF, 32'h5678FFFF, 0, 0, 2'b00);
    #3 rst_n = 0;
    #1;
    chk("arst_r0", result_0, 32'd0);
    chk("arst_r1", result_1, 32'd0);
    chk("arst_c", {30'b0, result_SIMD_carry}, 32'd0);
    @(posedge clk);
    #1;
    chk("hold_r0", result_0, 32'd0);
    #2 rst_n = 1;
    a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; mode = 2'b01;
    #1;
    chk("rel_r0", result_0, 32'd0);
    chk("rel_c", {30'b0, result_SIMD_carry}, 32'd0);
    step(32'h0000FFFF, 32'h0000FFFF, 0, 0, 2'b00);
    step(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 2'b01);
    step(32'h0000FFFF, 32'h00000002, 1, 1, 2'b00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
